// File: rtl/ysyx_220053_imem_resp.sv
// ysyx_220053_imem_resp: single-outstanding instruction-fetch responder.
// Accepts one fetch at a time and checks its alignment and address window.
// A good fetch reads one 64-bit memory beat and returns the selected 32-bit
// word after LATENCY cycles. A faulting fetch answers with resp_err=1 and
// does not touch memory.
//
// Ports
//   clk, rst       clock; asynchronous active-low reset
//   req_valid/_ready/_addr   fetch request handshake, 64-bit byte PC
//   flush          synchronous cancel; wins over everything else
//   resp_valid/_ready        response handshake
//   resp_data/_err           instruction word / access fault
//   mem_en/_addr/_rdata      backing-memory read port (data valid same cycle)
module ysyx_220053_imem_resp #(
  parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
  parameter logic [63:0] SIZE    = 64'h0000_0000_0800_0000,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        mem_en,
  output logic [63:0] mem_addr,
  input  logic [63:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 32;
  localparam logic [ADDR_W-1:0] LIMIT = BASE + SIZE;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Byte-offset bits [1:0] are only needed for the fault check at accept time.
  logic [ADDR_W-1:2]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               err_q, err_d;

  logic               in_window;
  logic               fault;
  logic               accept;
  logic               first_wait;

  // Fault classification on the live request address.
  always_comb begin
    in_window = (req_addr >= BASE) && (req_addr < LIMIT);
    fault     = (req_addr[1:0] != 2'b00) || !in_window;
  end

  // Handshake and memory strobe. The counter equals its load value only in
  // the first WAIT cycle, so it doubles as the first-cycle marker.
  always_comb begin
    req_ready  = rst && (state_q == S_IDLE) && !flush;
    accept     = req_valid && req_ready;
    first_wait = (state_q == S_WAIT) && (cnt_q == CNT_LOAD);
    mem_en     = first_wait && !flush;
    mem_addr   = mem_en ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    resp_valid = (state_q == S_RESP);
    resp_data  = data_q;
    resp_err   = err_q;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_d = req_addr[ADDR_W-1:2];
            if (fault) begin
              state_d = S_RESP;
              err_d   = 1'b1;
              data_d  = '0;
            end else begin
              state_d = S_WAIT;
              cnt_d   = CNT_LOAD;
              err_d   = 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (first_wait) begin
            data_d = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          end
          if (cnt_q == '0) begin
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_220053_imem_resp.sv
// Bench for ysyx_220053_imem_resp: three instances (LATENCY 1, 3, 4) share
// stimulus; a vector table covers fetch outcomes, directed sequences cover
// stall, flush and reset corners.
module tb_ysyx_220053_imem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        flush;
  logic        resp_ready;
  logic [63:0] mem_rdata;

  logic        req_ready_w  [3];
  logic        resp_valid_w [3];
  logic        resp_err_w   [3];
  logic        mem_en_w     [3];
  logic [31:0] resp_data_w  [3];
  logic [63:0] mem_addr_w   [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_220053_imem_resp #(.LATENCY(1)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_w[0]),
    .req_addr(req_addr), .flush(flush), .resp_valid(resp_valid_w[0]),
    .resp_ready(resp_ready), .resp_data(resp_data_w[0]), .resp_err(resp_err_w[0]),
    .mem_en(mem_en_w[0]), .mem_addr(mem_addr_w[0]), .mem_rdata(mem_rdata));
  ysyx_220053_imem_resp #(.LATENCY(3)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_w[1]),
    .req_addr(req_addr), .flush(flush), .resp_valid(resp_valid_w[1]),
    .resp_ready(resp_ready), .resp_data(resp_data_w[1]), .resp_err(resp_err_w[1]),
    .mem_en(mem_en_w[1]), .mem_addr(mem_addr_w[1]), .mem_rdata(mem_rdata));
  ysyx_220053_imem_resp #(.LATENCY(4)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_w[2]),
    .req_addr(req_addr), .flush(flush), .resp_valid(resp_valid_w[2]),
    .resp_ready(resp_ready), .resp_data(resp_data_w[2]), .resp_err(resp_err_w[2]),
    .mem_en(mem_en_w[2]), .mem_addr(mem_addr_w[2]), .mem_rdata(mem_rdata));

  typedef struct {
    logic [63:0] addr;
    logic [63:0] rdata;
    logic        err;
    logic [31:0] data;
    logic [63:0] maddr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  // One fetch with resp_ready held high; sample at each negedge after accept.
  task automatic run_fetch(input logic [63:0] addr, input logic [63:0] rdata,
                           input logic exp_err, input logic [31:0] exp_data,
                           input logic [63:0] exp_maddr, input string tag);
    int          en_cnt [3];
    int          en_cyc [3];
    logic [63:0] ma     [3];
    int          rv_cnt [3];
    int          rv_cyc [3];
    logic [31:0] rd     [3];
    logic        re     [3];
    for (int i = 0; i < 3; i++) begin
      en_cnt[i] = 0; en_cyc[i] = 0; ma[i] = '0;
      rv_cnt[i] = 0; rv_cyc[i] = 0; rd[i] = '0; re[i] = 1'b0;
    end
    @(negedge clk);
    mem_rdata  = rdata;
    req_addr   = addr;
    req_valid  = 1'b1;
    resp_ready = 1'b1;
    flush      = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s ready%0d", tag, i), 64'(req_ready_w[i]), 64'd1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (mem_en_w[i]) begin
          en_cnt[i]++;
          en_cyc[i] = c;
          ma[i] = mem_addr_w[i];
        end
        if (resp_valid_w[i]) begin
          if (rv_cnt[i] == 0) begin
            rv_cyc[i] = c;
            rd[i] = resp_data_w[i];
            re[i] = resp_err_w[i];
          end
          rv_cnt[i]++;
        end
      end
      req_valid = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s err%0d", tag, i), 64'(re[i]), 64'(exp_err));
      chk($sformatf("%s data%0d", tag, i), 64'(rd[i]), 64'(exp_data));
      chk($sformatf("%s nresp%0d", tag, i), 64'(rv_cnt[i]), 64'd1);
      chk($sformatf("%s rcyc%0d", tag, i), 64'(rv_cyc[i]),
          exp_err ? 64'd1 : 64'(lat(i) + 1));
      chk($sformatf("%s nmem%0d", tag, i), 64'(en_cnt[i]), exp_err ? 64'd0 : 64'd1);
      if (!exp_err) begin
        chk($sformatf("%s mcyc%0d", tag, i), 64'(en_cyc[i]), 64'd1);
        chk($sformatf("%s maddr%0d", tag, i), ma[i], exp_maddr);
      end
    end
  endtask

  initial begin
    int cnt;
    vecs[0] = '{64'h8000_0004, 64'hAABBCCDD_11223344, 1'b0, 32'hAABBCCDD, 64'h8000_0000};
    vecs[1] = '{64'h8000_0000, 64'h55667788_99AABBCC, 1'b0, 32'h99AABBCC, 64'h8000_0000};
    vecs[2] = '{64'h8000_0002, 64'h12345678_9ABCDEF0, 1'b1, 32'h0,        64'h0};
    vecs[3] = '{64'h7FFF_FFFC, 64'h12345678_9ABCDEF0, 1'b1, 32'h0,        64'h0};
    vecs[4] = '{64'h87FF_FFFC, 64'h0A0B0C0D_01020304, 1'b0, 32'h0A0B0C0D, 64'h87FF_FFF8};
    vecs[5] = '{64'h8800_0000, 64'h12345678_9ABCDEF0, 1'b1, 32'h0,        64'h0};
    vecs[6] = '{64'h8000_000C, 64'h01234567_89ABCDEF, 1'b0, 32'h01234567, 64'h8000_0008};
    vecs[7] = '{64'hFFFF_FFFF_8000_0000, 64'h1, 1'b1, 32'h0,              64'h0};

    // Reset values.
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    resp_ready = 1'b0; mem_rdata = '0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst ready%0d", i), 64'(req_ready_w[i]), 64'd0);
      chk($sformatf("rst rvalid%0d", i), 64'(resp_valid_w[i]), 64'd0);
      chk($sformatf("rst rdata%0d", i), 64'(resp_data_w[i]), 64'd0);
      chk($sformatf("rst rerr%0d", i), 64'(resp_err_w[i]), 64'd0);
      chk($sformatf("rst memen%0d", i), 64'(mem_en_w[i]), 64'd0);
      chk($sformatf("rst maddr%0d", i), mem_addr_w[i], 64'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("post-rst ready%0d", i), 64'(req_ready_w[i]), 64'd1);

    // Vector table.
    for (int v = 0; v < 8; v++)
      run_fetch(vecs[v].addr, vecs[v].rdata, vecs[v].err, vecs[v].data,
                vecs[v].maddr, $sformatf("vec%0d", v));

    // Stalled response: data latched and stable, no accept while in RESP.
    @(negedge clk);
    mem_rdata = 64'h11112222_33334444; req_addr = 64'h8000_0000;
    req_valid = 1'b1; resp_ready = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) mem_rdata = 64'hDEADBEEF_CAFEF00D;
      if (c == 3) chk("hold rvalid early", 64'(resp_valid_w[1]), 64'd0);
      if (c >= 4) begin
        chk($sformatf("hold rvalid c%0d", c), 64'(resp_valid_w[1]), 64'd1);
        chk($sformatf("hold rdata c%0d", c), 64'(resp_data_w[1]), 64'h33334444);
        chk($sformatf("hold ready c%0d", c), 64'(req_ready_w[1]), 64'd0);
      end
      if (c >= 6) chk($sformatf("hold rdata2 c%0d", c), 64'(resp_data_w[2]), 64'h33334444);
      if (c == 10) resp_ready = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold drained%0d", i), 64'(resp_valid_w[i]), 64'd0);
      chk($sformatf("hold idle%0d", i), 64'(req_ready_w[i]), 64'd1);
    end

    // Flush in second WAIT cycle of the LATENCY=4 instance.
    mem_rdata = 64'h0F0F0F0F_F0F0F0F0; req_addr = 64'h8000_0000;
    req_valid = 1'b1; resp_ready = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c >= 3 && resp_valid_w[2]) cnt++;
      if (c >= 3 && resp_valid_w[1]) cnt++;
      req_valid = 1'b0;
      if (c == 2) begin
        flush = 1'b1;
        #1;
        chk("flush ready", 64'(req_ready_w[2]), 64'd0);
        chk("flush memen", 64'(mem_en_w[2]), 64'd0);
      end
      if (c == 3) begin
        chk("flush idle rvalid", 64'(resp_valid_w[2]), 64'd0);
        chk("flush held ready", 64'(req_ready_w[2]), 64'd0);
        flush = 1'b0;
        #1;
        chk("flush released ready", 64'(req_ready_w[2]), 64'd1);
      end
    end
    chk("flush no response", 64'(cnt), 64'd0);
    run_fetch(64'h8000_0008, 64'h77778888_55556666, 1'b0, 32'h55556666,
              64'h8000_0008, "postflush");

    // Flush in first WAIT cycle suppresses mem_en; request under flush ignored.
    @(negedge clk);
    req_addr = 64'h8000_0000; req_valid = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("flush1 memen%0d", i), 64'(mem_en_w[i]), 64'd0);
    @(negedge clk);
    req_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("flush1 rvalid%0d", i), 64'(resp_valid_w[i]), 64'd0);
      chk($sformatf("flush1 ready%0d", i), 64'(req_ready_w[i]), 64'd0);
    end
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("noaccept memen%0d", i), 64'(mem_en_w[i]), 64'd0);
      chk($sformatf("noaccept rvalid%0d", i), 64'(resp_valid_w[i]), 64'd0);
    end

    // Reset asserted while all instances sit in RESP.
    @(negedge clk);
    mem_rdata = 64'hABCD0123_4567890A; req_addr = 64'h8000_0004;
    req_valid = 1'b1; resp_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    chk("prereset rvalid", 64'(resp_valid_w[2]), 64'd1);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst rvalid%0d", i), 64'(resp_valid_w[i]), 64'd0);
      chk($sformatf("midrst ready%0d", i), 64'(req_ready_w[i]), 64'd0);
      chk($sformatf("midrst rdata%0d", i), 64'(resp_data_w[i]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("relrst ready%0d", i), 64'(req_ready_w[i]), 64'd1);
      chk($sformatf("relrst rvalid%0d", i), 64'(resp_valid_w[i]), 64'd0);
    end
    run_fetch(64'h8000_0014, 64'h13579BDF_2468ACE0, 1'b0, 32'h13579BDF,
              64'h8000_0010, "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
